// File: rtl/tmr_scrubber.sv
// tmr_scrubber: background scrubber for a triple-replicated SRAM. Votes each word and rewrites
// all replicas on disagreement. Define SCRUB_REPLICA_CNT_EN to add per-replica fault counters.
module tmr_scrubber #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_host_req,
    output logic              o_host_gnt,
    input  logic [DATA_W-1:0] i_rd0,
    input  logic [DATA_W-1:0] i_rd1,
    input  logic [DATA_W-1:0] i_rd2,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic [CNT_W-1:0]  o_triple_cnt,
    output logic [ADDR_W-1:0] o_last_err_addr
`ifdef SCRUB_REPLICA_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_rep0_cnt,
    output logic [CNT_W-1:0]  o_rep1_cnt,
    output logic [CNT_W-1:0]  o_rep2_cnt
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCheck,
        StWrite,
        StNext,
        StDone,
        StHold
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_host_gnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [CNT_W-1:0]    r_triple_cnt;
    logic [ADDR_W-1:0]   r_last_err_addr;

    state_e              w_state_d;
    logic [ADDR_W-1:0]   w_addr_d;
    logic                w_mem_en_d;
    logic                w_mem_we_d;
    logic [DATA_W-1:0]   w_mem_wdata_d;
    logic [CNT_W-1:0]    w_err_cnt_d;
    logic [CNT_W-1:0]    w_triple_cnt_d;
    logic [ADDR_W-1:0]   w_last_err_addr_d;

    logic [DATA_W-1:0]   w_vote;
    logic                w_mismatch;
    logic                w_triple;
    logic                w_check_commit;

`ifdef SCRUB_REPLICA_CNT_EN
    logic [CNT_W-1:0]    r_rep0_cnt;
    logic [CNT_W-1:0]    r_rep1_cnt;
    logic [CNT_W-1:0]    r_rep2_cnt;
    logic [CNT_W-1:0]    w_rep0_cnt_d;
    logic [CNT_W-1:0]    w_rep1_cnt_d;
    logic [CNT_W-1:0]    w_rep2_cnt_d;
`endif

    assign w_vote     = (i_rd0 & i_rd1) | (i_rd0 & i_rd2) | (i_rd1 & i_rd2);
    assign w_mismatch = (i_rd0 != w_vote) || (i_rd1 != w_vote) || (i_rd2 != w_vote);
    assign w_triple   = (i_rd0 != i_rd1) && (i_rd0 != i_rd2) && (i_rd1 != i_rd2);

    // A CHECK abandoned to the host must leave every counter untouched.
    assign w_check_commit = (r_state == StCheck) && !i_host_req && w_mismatch;

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StIssue;
                    w_addr_d  = '0;
                end
            end
            StIssue: w_state_d = i_host_req ? StHold : StWait;
            StWait:  w_state_d = i_host_req ? StHold : StCheck;
            StCheck: begin
                if (i_host_req) begin
                    w_state_d = StHold;
                end else if (w_mismatch) begin
                    w_state_d = StWrite;
                end else begin
                    w_state_d = StNext;
                end
            end
            // The write strobe is already on the port, so it always completes first.
            StWrite: w_state_d = i_host_req ? StHold : StNext;
            StNext: begin
                if (i_host_req) begin
                    w_state_d = StHold;
                end else if (r_addr == LastAddr) begin
                    w_state_d = StDone;
                    w_addr_d  = '0;
                end else begin
                    w_state_d = StIssue;
                    w_addr_d  = r_addr + ADDR_W'(1);
                end
            end
            StDone: begin
                if (i_host_req) begin
                    w_state_d = StHold;
                end else if (i_continuous) begin
                    w_state_d = StIssue;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StHold:  w_state_d = i_host_req ? StHold : StIssue;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_err_cnt_d       = r_err_cnt;
        w_triple_cnt_d    = r_triple_cnt;
        w_last_err_addr_d = r_last_err_addr;
        if (w_check_commit) begin
            w_err_cnt_d       = sat_inc(r_err_cnt);
            w_last_err_addr_d = r_addr;
            if (w_triple) begin
                w_triple_cnt_d = sat_inc(r_triple_cnt);
            end
        end
    end

`ifdef SCRUB_REPLICA_CNT_EN
    always_comb begin
        w_rep0_cnt_d = r_rep0_cnt;
        w_rep1_cnt_d = r_rep1_cnt;
        w_rep2_cnt_d = r_rep2_cnt;
        if (w_check_commit) begin
            if (i_rd0 != w_vote) w_rep0_cnt_d = sat_inc(r_rep0_cnt);
            if (i_rd1 != w_vote) w_rep1_cnt_d = sat_inc(r_rep1_cnt);
            if (i_rd2 != w_vote) w_rep2_cnt_d = sat_inc(r_rep2_cnt);
        end
    end
`endif

    // Port outputs are registered from the next state so they line up with the state itself.
    always_comb begin
        w_mem_en_d    = (w_state_d == StIssue) || (w_state_d == StWrite);
        w_mem_we_d    = (w_state_d == StWrite);
        w_mem_wdata_d = (w_state_d == StWrite) ? w_vote : r_mem_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StIdle;
            r_addr          <= '0;
            r_mem_en        <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_host_gnt      <= 1'b1;
            r_err_cnt       <= '0;
            r_triple_cnt    <= '0;
            r_last_err_addr <= '0;
        end else begin
            r_state         <= w_state_d;
            r_addr          <= w_addr_d;
            r_mem_en        <= w_mem_en_d;
            r_mem_we        <= w_mem_we_d;
            r_mem_addr      <= w_addr_d;
            r_mem_wdata     <= w_mem_wdata_d;
            r_busy          <= (w_state_d != StIdle);
            r_done          <= (w_state_d == StDone);
            r_host_gnt      <= (w_state_d == StIdle) || (w_state_d == StHold);
            r_err_cnt       <= w_err_cnt_d;
            r_triple_cnt    <= w_triple_cnt_d;
            r_last_err_addr <= w_last_err_addr_d;
        end
    end

`ifdef SCRUB_REPLICA_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep0_cnt <= '0;
            r_rep1_cnt <= '0;
            r_rep2_cnt <= '0;
        end else begin
            r_rep0_cnt <= w_rep0_cnt_d;
            r_rep1_cnt <= w_rep1_cnt_d;
            r_rep2_cnt <= w_rep2_cnt_d;
        end
    end

    assign o_rep0_cnt = r_rep0_cnt;
    assign o_rep1_cnt = r_rep1_cnt;
    assign o_rep2_cnt = r_rep2_cnt;
`endif

    assign o_host_gnt      = r_host_gnt;
    assign o_mem_en        = r_mem_en;
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err_cnt       = r_err_cnt;
    assign o_triple_cnt    = r_triple_cnt;
    assign o_last_err_addr = r_last_err_addr;

endmodule

// File: tb/tb_tmr_scrubber.sv
// tb_tmr_scrubber: self-checking bench for tmr_scrubber with a 2-cycle-latency replicated memory
// model, a fault table, directed preemption/reset sequences and random continuous sweeps.
`timescale 1ns/1ps
module tb_tmr_scrubber;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 48;
    localparam int unsigned CW    = 6;
    localparam int unsigned PW    = 3 * DW;
    localparam int          CMAXI = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start, continuous, host_req;
    logic          host_gnt, mem_en, mem_we, busy, done;
    logic [AW-1:0] mem_addr, last_err_addr;
    logic [DW-1:0] mem_wdata, rd0, rd1, rd2;
    logic [CW-1:0] err_cnt, triple_cnt;
`ifdef SCRUB_REPLICA_CNT_EN
    logic [CW-1:0] rep0_cnt, rep1_cnt, rep2_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmr_scrubber #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_continuous   (continuous),
        .i_host_req     (host_req),
        .o_host_gnt     (host_gnt),
        .i_rd0          (rd0),
        .i_rd1          (rd1),
        .i_rd2          (rd2),
        .o_mem_en       (mem_en),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_busy         (busy),
        .o_done         (done),
        .o_err_cnt      (err_cnt),
        .o_triple_cnt   (triple_cnt),
        .o_last_err_addr(last_err_addr)
`ifdef SCRUB_REPLICA_CNT_EN
        ,
        .o_rep0_cnt     (rep0_cnt),
        .o_rep1_cnt     (rep1_cnt),
        .o_rep2_cnt     (rep2_cnt)
`endif
    );

    // Replicated memory: read data appears two cycles after the read command.
    logic [DW-1:0] m0 [DEPTH];
    logic [DW-1:0] m1 [DEPTH];
    logic [DW-1:0] m2 [DEPTH];
    logic [PW-1:0] pipe1, pipe2;
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t wlog[$];

    assign {rd0, rd1, rd2} = pipe2;

    always @(posedge clk) begin
        if (mem_en && !mem_we) pipe1 <= {m0[mem_addr], m1[mem_addr], m2[mem_addr]};
        else                   pipe1 <= PW'($urandom);
        pipe2 <= pipe1;
        if (mem_en && mem_we) begin
            m0[mem_addr] <= mem_wdata;
            m1[mem_addr] <= mem_wdata;
            m2[mem_addr] <= mem_wdata;
            wlog.push_back('{a: mem_addr, d: mem_wdata});
        end
    end

    // Reference model state
    logic [DW-1:0] exp_mem [DEPTH];
    int e_err, e_trip, e_last;
    int d_err, d_trip, d_last;
    int e_rep[3];
    int d_rep[3];

    typedef struct {
        int         addr;
        logic [7:0] r0, r1, r2, vote;
        bit         wr, trip;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] majority(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] v;
        for (int i = 0; i < int'(DW); i++) begin
            v[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        end
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAXI) ? CMAXI : v;
    endfunction

    // Predict one full sweep over the current memory image.
    task automatic model_sweep();
        logic [DW-1:0] v;
        d_err = 0; d_trip = 0; d_last = -1;
        for (int r = 0; r < 3; r++) d_rep[r] = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            v = majority(m0[a], m1[a], m2[a]);
            exp_mem[a] = v;
            if (!(m0[a] == m1[a] && m1[a] == m2[a])) begin
                d_err++;
                d_last = a;
                if (m0[a] != m1[a] && m0[a] != m2[a] && m1[a] != m2[a]) d_trip++;
                if (m0[a] != v) d_rep[0]++;
                if (m1[a] != v) d_rep[1]++;
                if (m2[a] != v) d_rep[2]++;
            end
        end
        e_err  = sat(e_err + d_err);
        e_trip = sat(e_trip + d_trip);
        if (d_last >= 0) e_last = d_last;
        for (int r = 0; r < 3; r++) e_rep[r] = sat(e_rep[r] + d_rep[r]);
    endtask

    task automatic clear_model();
        e_err = 0; e_trip = 0; e_last = 0;
        for (int r = 0; r < 3; r++) e_rep[r] = 0;
    endtask

    task automatic fill_clean();
        logic [DW-1:0] v;
        for (int a = 0; a < int'(DEPTH); a++) begin
            v = DW'($urandom);
            m0[a] = v; m1[a] = v; m2[a] = v;
        end
    endtask

    task automatic inject_random(input int k);
        int a;
        logic [DW-1:0] v, m1x, m2x;
        for (int i = 0; i < k; i++) begin
            a = $urandom_range(0, DEPTH - 1);
            v = DW'($urandom);
            m1x = DW'($urandom_range(1, 127));
            m2x = DW'($urandom_range(128, 255));
            case ($urandom_range(0, 3))
                0:       begin m0[a] = v ^ m1x; m1[a] = v;       m2[a] = v;       end
                1:       begin m0[a] = v;       m1[a] = v ^ m1x; m2[a] = v;       end
                2:       begin m0[a] = v;       m1[a] = v;       m2[a] = v ^ m2x; end
                default: begin m0[a] = v;       m1[a] = v ^ m1x; m2[a] = v ^ m2x; end
            endcase
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit rnd);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            if (rnd) host_req = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            n++;
        end
        host_req = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s: no done pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_err_cnt"}, err_cnt, e_err);
        chk({tag, "_triple_cnt"}, triple_cnt, e_trip);
        chk({tag, "_last_err_addr"}, last_err_addr, e_last);
`ifdef SCRUB_REPLICA_CNT_EN
        chk({tag, "_rep0"}, rep0_cnt, e_rep[0]);
        chk({tag, "_rep1"}, rep1_cnt, e_rep[1]);
        chk({tag, "_rep2"}, rep2_cnt, e_rep[2]);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_host_gnt"}, host_gnt, 1);
        clear_model();
        check_counters(tag);
    endtask

    task automatic check_mem_image(input string name);
        int bad = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            if (m0[a] !== exp_mem[a] || m1[a] !== exp_mem[a] || m2[a] !== exp_mem[a]) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, tbl_err, tbl_trip, tbl_last, tbl_rep0, wd;
        bit found, stayed_idle;

        start = 0; continuous = 0; host_req = 0;
        vecs[0] = '{10, 8'h00, 8'h2C, 8'h2C, 8'h2C, 1'b1, 1'b0};
        vecs[1] = '{20, 8'hFF, 8'h0F, 8'h3C, 8'h3F, 1'b1, 1'b1};
        vecs[2] = '{ 5, 8'h55, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0};
        vecs[3] = '{ 7, 8'hA5, 8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0};
        vecs[4] = '{12, 8'h81, 8'h42, 8'h81, 8'h81, 1'b1, 1'b0};
        vecs[5] = '{15, 8'hF0, 8'h0F, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{33, 8'h12, 8'h34, 8'h34, 8'h34, 1'b1, 1'b0};
        fill_clean();
        pipe1 = '0; pipe2 = '0;

        #2 rst_n = 1'b0;
        #6 check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_gnt", host_gnt, 1);

        // Clean sweep, with a stray start mid-sweep that must be ignored
        wlog.delete();
        pulse_start();
        chk("clean_issue0", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 8'd0});
        n = 0;
        while (done !== 1'b1 && n < int'(4 * DEPTH) + 20) begin
            @(negedge clk);
            n++;
            start = (n == 50);
        end
        start = 1'b0;
        chk("clean_sweep_cycles", n + 1, 4 * DEPTH + 1);
        chk("clean_no_writes", wlog.size(), 0);
        chk("clean_err_cnt", err_cnt, 0);
        @(negedge clk);
        chk("clean_busy_after", busy, 0);
        repeat (5) @(negedge clk);
        chk("clean_no_restart", {busy, mem_en}, 2'b00);

        // Fault table sweep
        fill_clean();
        tbl_err = 0; tbl_trip = 0; tbl_last = 0; tbl_rep0 = 0;
        for (int i = 0; i < 7; i++) begin
            m0[vecs[i].addr] = vecs[i].r0;
            m1[vecs[i].addr] = vecs[i].r1;
            m2[vecs[i].addr] = vecs[i].r2;
            if (vecs[i].wr) begin
                tbl_err++;
                if (vecs[i].addr > tbl_last) tbl_last = vecs[i].addr;
                if (vecs[i].r0 != vecs[i].vote) tbl_rep0++;
            end
            if (vecs[i].trip) tbl_trip++;
        end
        model_sweep();
        wlog.delete();
        pulse_start();
        wait_done("tbl_done", 4 * DEPTH + 50, 1'b0);
        for (int i = 0; i < 7; i++) begin
            found = 0; wd = 0;
            foreach (wlog[j]) begin
                if (int'(wlog[j].a) == vecs[i].addr) begin found = 1; wd = int'(wlog[j].d); end
            end
            chk($sformatf("tbl%0d_write_seen", i), found, vecs[i].wr);
            if (vecs[i].wr) chk($sformatf("tbl%0d_wdata", i), wd, vecs[i].vote);
            chk($sformatf("tbl%0d_mem", i),
                {m0[vecs[i].addr], m1[vecs[i].addr], m2[vecs[i].addr]}, {3{vecs[i].vote}});
        end
        chk("tbl_err_cnt", err_cnt, tbl_err);
        chk("tbl_triple_cnt", triple_cnt, tbl_trip);
        chk("tbl_last_err_addr", last_err_addr, tbl_last);
`ifdef SCRUB_REPLICA_CNT_EN
        chk("tbl_rep0", rep0_cnt, tbl_rep0);
`endif
        check_counters("tbl_model");

        // Host preemption during WAIT at address 30
        m0[30] = 8'h77; m1[30] = 8'h77; m2[30] = 8'h70;
        pulse_start();
        n = 0;
        while (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr == 30) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("pre_issue30_seen", mem_addr, 30);
        @(negedge clk);
        chk("pre_wait_en", mem_en, 0);
        host_req = 1'b1;
        @(negedge clk);
        chk("pre_hold_gnt", {host_gnt, mem_en, busy}, 3'b101);
        @(negedge clk);
        @(negedge clk);
        host_req = 1'b0;
        chk("pre_no_count", err_cnt, e_err);
        @(negedge clk);
        chk("pre_reissue30", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 8'd30});
        model_sweep();
        wait_done("pre_done", 4 * DEPTH + 50, 1'b0);
        check_counters("pre");
        chk("pre_mem30", {m0[30], m1[30], m2[30]}, {3{8'h77}});

        // Random faults, continuous sweeps, random host traffic, counter saturation
        inject_random(30);
        model_sweep();
        continuous = 1'b1;
        pulse_start();
        for (int s = 0; s < 5; s++) begin
            wait_done($sformatf("cont%0d_done", s), 3000, (s == 1 || s == 2));
            check_counters($sformatf("cont%0d", s));
            check_mem_image($sformatf("cont%0d_mem", s));
            if (s < 3) begin
                inject_random(30);
                model_sweep();
            end
            if (s == 4) continuous = 1'b0;
            @(negedge clk);
            if (s == 0) chk("wrap_issue0", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 8'd0});
        end
        chk("cont_stop_busy", busy, 0);
        chk("err_saturated", err_cnt, CMAXI);

        // Reset asserted in the middle of WRITE at address 10
        m0[10] = 8'h00; m1[10] = 8'h2C; m2[10] = 8'h2C;
        pulse_start();
        n = 0;
        while (!(mem_we === 1'b1 && mem_addr == 10) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rst_write10_seen", {mem_we, mem_addr}, {1'b1, 8'd10});
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stayed_idle = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || mem_en !== 1'b0 || host_gnt !== 1'b1) stayed_idle = 0;
        end
        chk("rst_stays_idle", stayed_idle, 1);
        chk("rst_write_aborted", m0[10], 8'h00);
        model_sweep();
        pulse_start();
        wait_done("rst_rerun_done", 4 * DEPTH + 50, 1'b0);
        chk("rst_rerun_err", err_cnt, 1);
        check_counters("rst_rerun");
        chk("rst_rerun_mem10", {m0[10], m1[10], m2[10]}, {3{8'h2C}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tmr_scrubber.md
Name: tmr_scrubber

Overview:
- Background scrub initiator for the triple-replicated 8-bit SRAM.
- Sweeps every address and reads all three replicas. Forms the bitwise majority of the three reads. Writes the voted word back to all replicas when any replica disagrees.
- Sits beside the host on the memory port. The host always has priority, and the scrubber yields the port whenever the host requests it.

Parameters:
- ADDR_W, 8: address width.
- DATA_W, 8: data width.
- DEPTH, 256: number of words swept. The last swept address is DEPTH-1. DEPTH must be ≤ 2^ADDR_W.
- CNT_W, 16: width of the error counters.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle request to begin a sweep. Sampled only in IDLE.
- continuous, input, 1: when 1, a finished sweep wraps to address 0 with no new start.
- host_req, input, 1: host wants the memory port.
- host_gnt, output, 1: host owns the port. Memory-side outputs are don't-care to the shared port while this is 1.
- rd0, rd1, rd2, input, DATA_W each: raw read data from the three replicas.
- mem_en, output, 1: memory enable.
- mem_we, output, 1: write enable, broadcast to all three replicas.
- mem_addr, output, ADDR_W: memory address.
- mem_wdata, output, DATA_W: write data, broadcast to all three replicas.
- busy, output, 1: a sweep is in progress.
- done, output, 1: one-cycle pulse at the end of a sweep.
- err_cnt, output, CNT_W: number of corrected words. Saturates.
- triple_cnt, output, CNT_W: number of words where all three replicas differed pairwise. Saturates.
- last_err_addr, output, ADDR_W: address of the most recent mismatch.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - state=IDLE, addr=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, host_gnt=1.
  - err_cnt=0, triple_cnt=0, last_err_addr=0.
- All outputs are registered. Memory read latency is fixed: rd0..rd2 are valid two cycles after the cycle in which mem_en=1 and mem_we=0 are presented.
- States and transitions:
  - IDLE: busy=0, host_gnt=1. On start=1 go to ISSUE with addr=0.
  - ISSUE: mem_en=1, mem_we=0, mem_addr=addr. Next state is WAIT.
  - WAIT: mem_en=0. Next state is CHECK.
  - CHECK:
    - Compute vote = (rd0&rd1)|(rd0&rd2)|(rd1&rd2).
    - mismatch = (rd0!=vote)|(rd1!=vote)|(rd2!=vote).
    - triple = (rd0!=rd1)&(rd0!=rd2)&(rd1!=rd2).
    - If mismatch: err_cnt+1 (saturating), last_err_addr=addr, and triple_cnt+1 if triple. Then go to WRITE.
    - Otherwise go to NEXT.
  - WRITE: mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=vote. Next state is NEXT.
  - NEXT:
    - If addr==DEPTH-1: set addr=0 and go to DONE.
    - Otherwise: addr+1, then go to ISSUE.
  - DONE: done=1 for one cycle.
    - If continuous=1, go to ISSUE.
    - Otherwise go to IDLE.
  - HOLD: host_gnt=1, mem_en=0. When host_req=0, go to ISSUE for the same addr.
- Per-word cost:
  - A clean word takes 4 cycles (ISSUE, WAIT, CHECK, NEXT).
  - A corrected word takes 5 cycles.
  - A clean full sweep of DEPTH words takes 4·DEPTH+1 cycles from ISSUE(0) to the done pulse.
- busy=1 in every state except IDLE.
- host_gnt=1 in IDLE and HOLD. It is 0 otherwise.
- Host preemption:
  - host_req=1 seen in ISSUE, WAIT, CHECK, NEXT or DONE: the FSM goes to HOLD on the next edge. No counters are updated for a CHECK that is abandoned.
  - WRITE is never interrupted. The write completes, then HOLD is entered if host_req is still 1.
  - After HOLD, the interrupted address is re-read from ISSUE, because the host may have rewritten it.
- Boundary conditions:
  - start while busy is ignored.
  - Counters hold at all-ones on saturation.
  - Triple mismatch still writes vote.
  - rst_n asserted mid-WRITE: the write strobe drops immediately and all state is cleared.

Optional Feature:
- Macro: SCRUB_REPLICA_CNT_EN.
- When defined:
  - Adds outputs rep0_cnt, rep1_cnt, rep2_cnt, each CNT_W wide, saturating, reset to 0.
  - In CHECK, repN_cnt increments when rdN!=vote, but not for a CHECK abandoned on preemption.
  - Identifies which physical replica is degrading.
- When undefined: these ports and their registers do not exist, and all other behaviour is identical.

Test Plan:
- Clean sweep: all replicas equal at every address, start pulsed, continuous=0.
  - Expect no WRITE state.
  - Expect done exactly 4·DEPTH+1 cycles after ISSUE(0).
  - Expect err_cnt=0 and busy=0 afterwards.
- Single-replica fault: addr 10 holds rd0=00, rd1=2C, rd2=2C.
  - Expect a write of 2C to addr 10 and err_cnt=1.
  - Expect last_err_addr=10 and triple_cnt=0.
  - With the macro defined, expect rep0_cnt=1.
- Triple fault: addr 20 holds rd0=FF, rd1=0F, rd2=3C.
  - Expect vote=3F, a write of 3F to addr 20, err_cnt+1 and triple_cnt=1.
- Preemption: host_req=1 for 3 cycles while in WAIT at addr 30.
  - Expect HOLD with host_gnt=1.
  - Expect a re-ISSUE at addr 30 after release and no counter change from the abandoned read.
  - Expect correct correction if addr 30 is faulty.
- Continuous wrap: continuous=1.
  - Expect done to pulse, then an immediate ISSUE at addr 0.
  - Expect err_cnt to keep accumulating across sweeps.
  - Force err_cnt near all-ones and expect it to hold at all-ones.
- Reset mid-operation: drop rst_n during WRITE at addr 10.
  - Expect mem_we=0 immediately and all outputs at reset values.
  - After rst_n rises, expect the FSM to stay in IDLE until start.
